// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO write-side blocks.
// The optional statistics counters use ARB_STAT_W (enabled by FIFO_WRITE_ARB_STATS_EN).
package fifo_pkg;

    localparam logic [0:0] ARB_IDLE  = 1'b0;
    localparam logic [0:0] ARB_BURST = 1'b1;

    localparam int unsigned ARB_STAT_W = 16;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: first asserted req bit at or above rr_ptr, wrapping modulo NUM_REQ.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               valid
);

    logic [IDX_W-1:0] idx;

    // Scan from the farthest offset down so the nearest hit is written last.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = IDX_W'((32'(rr_ptr) + 32'(i)) % NUM_REQ);
            if (req[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one FIFO write port between NUM_REQ producers.
// Define FIFO_WRITE_ARB_STATS_EN to add per-producer beat counters and a stall counter.
module fifo_write_arbiter
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                          fifo_full,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          write_enable,
    output logic [DATA_WIDTH-1:0]         write_data
`ifdef FIFO_WRITE_ARB_STATS_EN
    ,
    output logic [NUM_REQ*ARB_STAT_W-1:0] grant_count,
    output logic [ARB_STAT_W-1:0]         stall_cycles
`endif
);

    localparam int unsigned IDX_W = clog2(NUM_REQ);
    localparam int unsigned BC_W  = clog2(MAX_BURST) + 1;

    logic [0:0]       state, state_next;
    logic [IDX_W-1:0] owner, owner_next;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_next;
    logic [BC_W-1:0]  beat_cnt, beat_cnt_next;

    logic             in_burst, req_own, accept, last_beat, burst_end;
    logic [IDX_W-1:0] owner_inc, pick_ptr, winner;
    logic             win_valid;

    assign in_burst  = (state == ARB_BURST);
    assign req_own   = req[owner];
    assign accept    = in_burst & req_own & ~fifo_full;
    assign last_beat = (beat_cnt == BC_W'(MAX_BURST - 1));
    assign burst_end = in_burst & (~req_own | (accept & last_beat));
    assign owner_inc = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

    // In BURST the pick only matters at burst end, where the advanced pointer applies.
    assign pick_ptr = in_burst ? owner_inc : rr_ptr;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (pick_ptr),
        .winner (winner),
        .valid  (win_valid)
    );

    always_comb begin
        grant = '0;
        if (in_burst) begin
            grant[owner] = 1'b1;
        end
    end

    assign write_enable = accept;
    assign write_data   = in_burst ? req_data[32'(owner)*DATA_WIDTH +: DATA_WIDTH] : '0;

    always_comb begin
        state_next    = state;
        owner_next    = owner;
        rr_ptr_next   = rr_ptr;
        beat_cnt_next = beat_cnt;
        if (!in_burst) begin
            if (win_valid) begin
                state_next    = ARB_BURST;
                owner_next    = winner;
                beat_cnt_next = '0;
            end
        end else if (burst_end) begin
            rr_ptr_next   = owner_inc;
            beat_cnt_next = '0;
            if (win_valid) begin
                owner_next = winner;
            end else begin
                state_next = ARB_IDLE;
            end
        end else if (accept) begin
            beat_cnt_next = beat_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ARB_IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_next;
            owner    <= owner_next;
            rr_ptr   <= rr_ptr_next;
            beat_cnt <= beat_cnt_next;
        end
    end

`ifdef FIFO_WRITE_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_count  <= '0;
            stall_cycles <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept && owner == IDX_W'(i) &&
                    grant_count[i*ARB_STAT_W +: ARB_STAT_W] != {ARB_STAT_W{1'b1}}) begin
                    grant_count[i*ARB_STAT_W +: ARB_STAT_W] <=
                        grant_count[i*ARB_STAT_W +: ARB_STAT_W] + 1'b1;
                end
            end
            if (in_burst && req_own && fifo_full && stall_cycles != {ARB_STAT_W{1'b1}}) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed self-checking bench for fifo_write_arbiter (NUM_REQ=4, MAX_BURST=4, DATA_WIDTH=8).
// Stats checks are compiled in when FIFO_WRITE_ARB_STATS_EN is defined.
module tb_fifo_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        fifo_full;
    logic [3:0]  grant;
    logic        write_enable;
    logic [7:0]  write_data;
`ifdef FIFO_WRITE_ARB_STATS_EN
    logic [63:0] grant_count;
    logic [15:0] stall_cycles;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    fifo_write_arbiter #(
        .DATA_WIDTH (8),
        .NUM_REQ    (4),
        .MAX_BURST  (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_data     (req_data),
        .fifo_full    (fifo_full),
        .grant        (grant),
        .write_enable (write_enable),
        .write_data   (write_data)
`ifdef FIFO_WRITE_ARB_STATS_EN
        ,
        .grant_count  (grant_count),
        .stall_cycles (stall_cycles)
`endif
    );

    // Inputs change 1 time unit after the edge; outputs are checked 2 units later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc();
        reset     = 1'b1;
        req       = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        cyc();
        reset     = 1'b1;
        req       = 4'b1111;
        req_data  = 32'hDEADBEEF;
        fifo_full = 1'b0;
        cyc();
        cyc();
        #2;
        tests_run++;
        if (grant !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_grant: got %b expected %b", grant, 4'b0000);
        end
        tests_run++;
        if (write_enable !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_we: got %b expected 0", write_enable);
        end
        tests_run++;
        if (write_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_wdata: got %h expected 00", write_data);
        end
        tests_run++;
        if (dut.rr_ptr !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_rr_ptr: got %0d expected 0", dut.rr_ptr);
        end
`ifdef FIFO_WRITE_ARB_STATS_EN
        tests_run++;
        if (grant_count !== 64'd0 || stall_cycles !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_stats: got %h/%h expected 0/0", grant_count, stall_cycles);
        end
`endif
    endtask

    task automatic test_single();
        do_reset();
        req      = 4'b0001;
        req_data = 32'h000000A5;
        #2;
        tests_run++;
        if (grant !== 4'b0000 || write_enable !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_idle_c0: got %b/%b expected 0000/0", grant, write_enable);
        end
        for (int c = 1; c <= 10; c++) begin
            cyc();
            #2;
            tests_run++;
            if (grant !== 4'b0001 || write_enable !== 1'b1 || write_data !== 8'hA5) begin
                tests_failed++;
                $display("FAIL single_beat c=%0d: got %b/%b/%h expected 0001/1/a5",
                         c, grant, write_enable, write_data);
            end
        end
        cyc();
        req = 4'b0000;
        #2;
        tests_run++;
        if (grant !== 4'b0001 || write_enable !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_drop: got %b/%b expected 0001/0", grant, write_enable);
        end
        cyc();
        #2;
        tests_run++;
        if (grant !== 4'b0000 || write_enable !== 1'b0 || write_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL single_idle_after: got %b/%b/%h expected 0000/0/00",
                     grant, write_enable, write_data);
        end
    endtask

    task automatic test_contention();
        logic [3:0] exp_grant;
        logic [7:0] exp_data;
        int         o;
        do_reset();
        req      = 4'b1111;
        req_data = 32'h44332211;
        #2;
        for (int c = 1; c <= 32; c++) begin
            cyc();
            #2;
            o         = ((c - 1) / 4) % 4;
            exp_grant = 4'b0001 << o;
            exp_data  = 8'(8'h11 * (o + 1));
            tests_run++;
            if (grant !== exp_grant || write_enable !== 1'b1 || write_data !== exp_data) begin
                tests_failed++;
                $display("FAIL contention c=%0d: got %b/%b/%h expected %b/1/%h",
                         c, grant, write_enable, write_data, exp_grant, exp_data);
            end
        end
`ifdef FIFO_WRITE_ARB_STATS_EN
        cyc();
        #2;
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (grant_count[i*16 +: 16] !== 16'd8) begin
                tests_failed++;
                $display("FAIL stats_grant_count[%0d]: got %0d expected 8",
                         i, grant_count[i*16 +: 16]);
            end
        end
        tests_run++;
        if (stall_cycles !== 16'd0) begin
            tests_failed++;
            $display("FAIL stats_stall_zero: got %0d expected 0", stall_cycles);
        end
`endif
    endtask

    task automatic test_full_stall();
        int accepted;
        accepted = 0;
        do_reset();
        req      = 4'b0100;
        req_data = 32'h00C30000;
        #2;
        for (int c = 1; c <= 8; c++) begin
            cyc();
            fifo_full = (c >= 3 && c <= 6);
            #2;
            if (write_enable === 1'b1) begin
                accepted++;
            end
            tests_run++;
            if (grant !== 4'b0100 || write_enable !== !(c >= 3 && c <= 6) ||
                write_data !== 8'hC3) begin
                tests_failed++;
                $display("FAIL full_stall c=%0d: got %b/%b/%h expected 0100/%0d/c3",
                         c, grant, write_enable, write_data, !(c >= 3 && c <= 6));
            end
        end
        tests_run++;
        if (accepted != 4) begin
            tests_failed++;
            $display("FAIL full_stall_beats: got %0d expected 4", accepted);
        end
        cyc();
        #2;
        tests_run++;
        if (dut.rr_ptr !== 2'd3 || grant !== 4'b0100) begin
            tests_failed++;
            $display("FAIL full_stall_end: got rr_ptr=%0d grant=%b expected 3/0100",
                     dut.rr_ptr, grant);
        end
`ifdef FIFO_WRITE_ARB_STATS_EN
        tests_run++;
        if (stall_cycles !== 16'd4) begin
            tests_failed++;
            $display("FAIL stats_stall_cycles: got %0d expected 4", stall_cycles);
        end
`endif
    endtask

    task automatic test_early_drop();
        do_reset();
        req      = 4'b1010;
        req_data = 32'h3C005A00;
        #2;
        for (int c = 1; c <= 2; c++) begin
            cyc();
            #2;
            tests_run++;
            if (grant !== 4'b0010 || write_enable !== 1'b1 || write_data !== 8'h5A) begin
                tests_failed++;
                $display("FAIL early_drop_beat c=%0d: got %b/%b/%h expected 0010/1/5a",
                         c, grant, write_enable, write_data);
            end
        end
        cyc();
        req = 4'b1000;
        #2;
        tests_run++;
        if (grant !== 4'b0010 || write_enable !== 1'b0) begin
            tests_failed++;
            $display("FAIL early_drop_cycle: got %b/%b expected 0010/0", grant, write_enable);
        end
        cyc();
        #2;
        tests_run++;
        if (grant !== 4'b1000 || write_enable !== 1'b1 || write_data !== 8'h3C) begin
            tests_failed++;
            $display("FAIL early_drop_switch: got %b/%b/%h expected 1000/1/3c",
                     grant, write_enable, write_data);
        end
        tests_run++;
        if (dut.rr_ptr !== 2'd2) begin
            tests_failed++;
            $display("FAIL early_drop_rr_ptr: got %0d expected 2", dut.rr_ptr);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req      = 4'b0011;
        req_data = 32'h0000B2B1;
        #2;
        cyc();
        #2;
        tests_run++;
        if (grant !== 4'b0001 || write_enable !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_reset_beat1: got %b/%b expected 0001/1", grant, write_enable);
        end
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        req   = 4'b0010;
        #2;
        tests_run++;
        if (grant !== 4'b0000 || write_enable !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_idle: got %b/%b expected 0000/0", grant, write_enable);
        end
        cyc();
        #2;
        tests_run++;
        if (grant !== 4'b0010 || write_enable !== 1'b1 || write_data !== 8'hB2) begin
            tests_failed++;
            $display("FAIL mid_reset_regrant: got %b/%b/%h expected 0010/1/b2",
                     grant, write_enable, write_data);
        end
    endtask

    initial begin
        reset     = 1'b1;
        req       = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_full_stall();
        test_early_drop();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
